// File: rtl/lcd_pkg.sv
// Shared command codes, payload geometry and FSM state encoding for the
// LCD request arbiter slice.
package lcd_pkg;

  localparam logic [2:0] CMD_REFLASH = 3'd0;
  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;

  localparam int unsigned LCD_LOAD_LEN = 36;
  localparam int unsigned LCD_OUT_LEN  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return cmd <= CMD_DOWN;
  endfunction

endpackage

// File: rtl/lcd_load_buf.sv
// LOAD payload register file: synchronous write at wr_ptr, combinational
// read at rd_ptr. Storage is never reset; only the pointers are.
module lcd_load_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_last,
  output logic              rd_last
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign wr_last = (wr_ptr == PTR_W'(DEPTH - 1));
  assign rd_last = (rd_ptr == PTR_W'(DEPTH - 1));

endmodule

// File: rtl/lcd_req_arbiter.sv
// Round-robin sharing of one lcd_ctrl between two requesters: buffers LOAD
// payloads, replays them gap-free, and routes the 3x3 response to the owner.
module lcd_req_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOAD_LEN = LCD_LOAD_LEN,
  parameter int unsigned OUT_LEN  = LCD_OUT_LEN,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          req_cmd,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [1:0]          req_data_valid,
  output logic [1:0]          req_data_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [1:0]          rsp_valid,
  output logic [1:0]          rsp_last,
  output logic [1:0]          req_err,
  output logic [2:0]          lcd_cmd,
  output logic                lcd_cmd_valid,
  output logic [DATA_W-1:0]   lcd_datain,
  input  logic                lcd_busy,
  input  logic [DATA_W-1:0]   lcd_dataout,
  input  logic                lcd_output_valid
);

  localparam int unsigned BEAT_W = $clog2(OUT_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);

  state_t            state, state_nxt;
  logic              owner, last_owner, grant;
  logic [2:0]        cmd, grant_cmd;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              any_req, issue_ok, beat, beat_last, timeout;
  logic              wr_en, rd_en, buf_clr, wr_last, rd_last;
  logic [DATA_W-1:0] wr_data, rd_data;

  assign any_req   = |req_valid;
  assign grant     = (&req_valid) ? ~last_owner : req_valid[1];
  assign grant_cmd = grant ? req_cmd[5:3] : req_cmd[2:0];
  assign issue_ok  = !lcd_busy && !lcd_output_valid;
  assign beat      = (state == ST_DRAIN) && lcd_output_valid;
  assign beat_last = beat && (beat_cnt == BEAT_W'(OUT_LEN - 1));
  assign timeout   = (state == ST_DRAIN) && !lcd_output_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

  assign wr_en   = (state == ST_COLLECT) && req_data_valid[owner];
  assign wr_data = owner ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
  // The command pulse occupies the first STREAM cycle; replay starts after it.
  assign rd_en   = (state == ST_STREAM) && !lcd_cmd_valid;

  lcd_load_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LOAD_LEN)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .wr_last (wr_last),
    .rd_last (rd_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (any_req && cmd_legal(grant_cmd))
          state_nxt = (grant_cmd == CMD_LOAD) ? ST_COLLECT : ST_ISSUE;
      end
      ST_COLLECT: if (wr_en && wr_last) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (issue_ok) state_nxt = (cmd == CMD_LOAD) ? ST_STREAM : ST_DRAIN;
      end
      ST_STREAM: if (rd_en && rd_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (beat_last || timeout) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = '0;
    req_data_ready = '0;
    buf_clr        = 1'b0;
    lcd_datain     = '0;
    if (state == ST_IDLE && any_req && !reset) begin
      req_ready[grant] = 1'b1;
      buf_clr          = (grant_cmd == CMD_LOAD);
    end
    if (state == ST_COLLECT) req_data_ready[owner] = 1'b1;
    if (rd_en) lcd_datain = rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      cmd           <= '0;
      beat_cnt      <= '0;
      tmo_cnt       <= '0;
      lcd_cmd_valid <= 1'b0;
      lcd_cmd       <= '0;
      rsp_data      <= '0;
      rsp_valid     <= '0;
      rsp_last      <= '0;
      req_err       <= '0;
    end else begin
      lcd_cmd_valid <= 1'b0;
      lcd_cmd       <= '0;
      rsp_data      <= '0;
      rsp_valid     <= '0;
      rsp_last      <= '0;
      req_err       <= '0;

      if (state == ST_IDLE && any_req) begin
        owner <= grant;
        cmd   <= grant_cmd;
        if (!cmd_legal(grant_cmd)) req_err[grant] <= 1'b1;
      end

      if (state == ST_ISSUE && issue_ok) begin
        lcd_cmd_valid <= 1'b1;
        lcd_cmd       <= cmd;
        beat_cnt      <= '0;
        tmo_cnt       <= '0;
      end

      if (beat) begin
        rsp_valid[owner] <= 1'b1;
        if (owner) rsp_data[2*DATA_W-1:DATA_W] <= lcd_dataout;
        else       rsp_data[DATA_W-1:0]        <= lcd_dataout;
        beat_cnt <= beat_cnt + BEAT_W'(1);
        tmo_cnt  <= '0;
        if (beat_last) begin
          rsp_last[owner] <= 1'b1;
          last_owner      <= owner;
        end
      end else if (state == ST_DRAIN) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (timeout) req_err[owner] <= 1'b1;
      end
    end
  end

endmodule
